// File: rtl/img_proc_ctrl.sv
// rtl/img_proc_ctrl.sv - image buffer controller: ROM load, 2x2 window ops, RAM write-out
module img_proc_ctrl #(
    parameter int DW = 8,
    parameter int SB = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    input  logic [DW-1:0]     IROM_Q,
    output logic              IROM_rd,
    output logic [2*SB-1:0]   IROM_A,
    output logic              IRAM_valid,
    output logic [DW-1:0]     IRAM_D,
    output logic [2*SB-1:0]   IRAM_A,
    output logic              busy,
    output logic              done
);
    localparam int AW    = 2 * SB;
    localparam int NN    = 1 << AW;
    localparam int NN_M1 = NN - 1;
    localparam logic [AW:0]   C_NN    = NN[AW:0];
    localparam logic [AW:0]   C_WLAST = NN_M1[AW:0];
    localparam logic [AW:0]   C_CNT1  = {{AW{1'b0}}, 1'b1};
    localparam logic [SB-1:0] C_ONE   = {{(SB-1){1'b0}}, 1'b1};
    localparam logic [SB-1:0] C_MAX   = {SB{1'b1}};
    localparam logic [SB-1:0] C_HALF  = {1'b1, {(SB-1){1'b0}}};

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [AW:0]     r_cnt;
    logic            r_ld_vld;
    logic [AW-1:0]   r_ld_addr;
    logic [SB-1:0]   r_px, r_py;
    logic [3:0]      r_cmd;
    logic            r_phase;
    logic [DW-1:0]   r_a, r_b, r_c, r_d;
    logic [DW-1:0]   r_buf [0:NN-1];

    logic            w_two;
    logic [SB-1:0]   w_pxm1, w_pym1;
    logic [AW-1:0]   w_addr_a, w_addr_b, w_addr_c, w_addr_d;
    logic [DW+1:0]   w_sum;
    logic [DW-1:0]   w_max_ab, w_max_cd, w_max, w_min_ab, w_min_cd, w_min;
    logic [DW-1:0]   w_na, w_nb, w_nc, w_nd;

    assign w_two    = (r_cmd >= 4'd5) && (r_cmd <= 4'd11);
    assign w_pxm1   = r_px - C_ONE;
    assign w_pym1   = r_py - C_ONE;
    assign w_addr_a = {w_pym1, w_pxm1};
    assign w_addr_b = {w_pym1, r_px};
    assign w_addr_c = {r_py, w_pxm1};
    assign w_addr_d = {r_py, r_px};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        IROM_rd    = 1'b0;
        IROM_A     = '0;
        IRAM_valid = 1'b0;
        IRAM_A     = '0;
        IRAM_D     = '0;
        done       = 1'b0;
        case (r_state)
            S_LOAD: begin
                // Final count value is the extra cycle that stores the last ROM word.
                IROM_rd = ~r_cnt[AW];
                IROM_A  = r_cnt[AW-1:0];
                if (r_cnt == C_NN) w_next = S_IDLE;
            end
            S_IDLE: begin
                busy = 1'b0;
                if (cmd_valid) begin
                    if (cmd == 4'd0)       w_next = S_WRITE;
                    else if (cmd == 4'd12) w_next = S_LOAD;
                    else                   w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!w_two || r_phase) w_next = S_IDLE;
            end
            S_WRITE: begin
                IRAM_valid = 1'b1;
                IRAM_A     = r_cnt[AW-1:0];
                IRAM_D     = r_buf[r_cnt[AW-1:0]];
                if (r_cnt == C_WLAST) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ld_vld  <= 1'b0;
            r_ld_addr <= '0;
            r_px      <= C_HALF;
            r_py      <= C_HALF;
            r_cmd     <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_ld_vld  <= IROM_rd;
            r_ld_addr <= IROM_A;
            if (r_state != w_next)
                r_cnt <= '0;
            else if (r_state == S_LOAD || r_state == S_WRITE)
                r_cnt <= r_cnt + C_CNT1;
            if (r_state == S_IDLE && cmd_valid) begin
                r_cmd   <= cmd;
                r_phase <= 1'b0;
            end
            if (r_state == S_EXEC) begin
                r_phase <= 1'b1;
                case (r_cmd)
                    4'd1:  if (r_py > C_ONE) r_py <= r_py - C_ONE;
                    4'd2:  if (r_py < C_MAX) r_py <= r_py + C_ONE;
                    4'd3:  if (r_px > C_ONE) r_px <= r_px - C_ONE;
                    4'd4:  if (r_px < C_MAX) r_px <= r_px + C_ONE;
                    4'd13: begin
                        r_px <= C_HALF;
                        r_py <= C_HALF;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Snapshot the window first so every rewrite sees pre-command values.
    always_ff @(posedge clk) begin
        if (r_state == S_EXEC && !r_phase) begin
            r_a <= r_buf[w_addr_a];
            r_b <= r_buf[w_addr_b];
            r_c <= r_buf[w_addr_c];
            r_d <= r_buf[w_addr_d];
        end
    end

    assign w_sum    = {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c} + {2'b00, r_d};
    assign w_max_ab = (r_a > r_b) ? r_a : r_b;
    assign w_max_cd = (r_c > r_d) ? r_c : r_d;
    assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
    assign w_min_ab = (r_a < r_b) ? r_a : r_b;
    assign w_min_cd = (r_c < r_d) ? r_c : r_d;
    assign w_min    = (w_min_ab < w_min_cd) ? w_min_ab : w_min_cd;

    always_comb begin
        w_na = r_a;
        w_nb = r_b;
        w_nc = r_c;
        w_nd = r_d;
        case (r_cmd)
            4'd5: begin
                w_na = w_max; w_nb = w_max; w_nc = w_max; w_nd = w_max;
            end
            4'd6: begin
                w_na = w_min; w_nb = w_min; w_nc = w_min; w_nd = w_min;
            end
            4'd7: begin
                w_na = w_sum[DW+1:2]; w_nb = w_sum[DW+1:2];
                w_nc = w_sum[DW+1:2]; w_nd = w_sum[DW+1:2];
            end
            4'd8: begin
                w_na = r_b; w_nb = r_d; w_nd = r_c; w_nc = r_a;
            end
            4'd9: begin
                w_na = r_c; w_nc = r_d; w_nd = r_b; w_nb = r_a;
            end
            4'd10: begin
                w_na = r_c; w_nc = r_a; w_nb = r_d; w_nd = r_b;
            end
            4'd11: begin
                w_na = r_b; w_nb = r_a; w_nc = r_d; w_nd = r_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && r_ld_vld)
            r_buf[r_ld_addr] <= IROM_Q;
        if (r_state == S_EXEC && r_phase && w_two) begin
            r_buf[w_addr_a] <= w_na;
            r_buf[w_addr_b] <= w_nb;
            r_buf[w_addr_c] <= w_nc;
            r_buf[w_addr_d] <= w_nd;
        end
    end
endmodule

// File: tb/tb_img_proc_ctrl.sv
// tb/tb_img_proc_ctrl.sv - directed self-checking bench for img_proc_ctrl
module tb_img_proc_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cmd_valid, IROM_rd, IRAM_valid, busy, done;
    logic [3:0] cmd;
    logic [7:0] IROM_Q, IRAM_D;
    logic [5:0] IROM_A, IRAM_A;

    logic       reset4, cmd_valid4, IROM_rd4, IRAM_valid4, busy4, done4;
    logic [3:0] cmd4;
    logic [7:0] IROM_Q4, IRAM_D4;
    logic [7:0] IROM_A4, IRAM_A4;

    img_proc_ctrl #(.DW(8), .SB(3)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
        .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
        .IRAM_A(IRAM_A), .busy(busy), .done(done)
    );

    img_proc_ctrl #(.DW(8), .SB(4)) dut4 (
        .clk(clk), .reset(reset4), .cmd(cmd4), .cmd_valid(cmd_valid4), .IROM_Q(IROM_Q4),
        .IROM_rd(IROM_rd4), .IROM_A(IROM_A4), .IRAM_valid(IRAM_valid4), .IRAM_D(IRAM_D4),
        .IRAM_A(IRAM_A4), .busy(busy4), .done(done4)
    );

    logic [7:0] rom  [0:63];
    logic [7:0] ram  [0:63];
    logic [7:0] exp_img [0:63];
    logic [7:0] rom4 [0:255];
    logic [7:0] ram4 [0:255];
    int wr_cnt = 0, done_cnt = 0, overlap = 0, wr4 = 0, done4_cnt = 0;
    int n_assert = 0, n_fail = 0;

    always @(posedge clk) begin
        if (IROM_rd)  IROM_Q  <= rom[IROM_A];
        if (IROM_rd4) IROM_Q4 <= rom4[IROM_A4];
    end

    always @(posedge clk) begin
        if (IRAM_valid) begin
            ram[IRAM_A] = IRAM_D;
            wr_cnt = wr_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            if (IRAM_valid) overlap = overlap + 1;
        end
        if (IRAM_valid4) begin
            ram4[IRAM_A4] = IRAM_D4;
            wr4 = wr4 + 1;
        end
        if (done4) done4_cnt = done4_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [3:0] c, input int expn, input string tag);
        int n;
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(n);
        chk({tag, " busy cycles"}, n, expn);
    endtask

    task automatic set_win(input int a, input int b, input int c, input int d, input int base);
        exp_img[base]     = a[7:0];
        exp_img[base + 1] = b[7:0];
        exp_img[base + 8] = c[7:0];
        exp_img[base + 9] = d[7:0];
    endtask

    task automatic write_check(input string tag);
        int w0, d0, bad;
        w0 = wr_cnt;
        d0 = done_cnt;
        run(4'd0, 65, {tag, " write"});
        chk({tag, " write count"}, wr_cnt - w0, 64);
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] !== exp_img[i]) bad++;
        chk({tag, " image mismatches"}, bad, 0);
    endtask

    task automatic reload();
        run(4'd12, 65, "reload");
        for (int i = 0; i < 64; i++) exp_img[i] = rom[i];
    endtask

    initial begin
        int n, bad;
        reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0;
        reset4 = 1'b1; cmd4 = 4'd0; cmd_valid4 = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        for (int i = 0; i < 256; i++) rom4[i] = 8'(i);
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", busy, 1);
        chk("reset IROM_rd", IROM_rd, 1);
        chk("reset IROM_A", IROM_A, 0);
        chk("reset IRAM_valid", IRAM_valid, 0);
        chk("reset IRAM_D", IRAM_D, 0);
        chk("reset IRAM_A", IRAM_A, 0);
        chk("reset done", done, 0);
        reset = 1'b0;
        wait_idle(n);
        chk("initial load cycles", n, 65);
        chk("IROM_rd after load", IROM_rd, 0);
        for (int i = 0; i < 64; i++) exp_img[i] = rom[i];
        write_check("copy");

        run(4'd5, 2, "max");
        set_win(36, 36, 36, 36, 27);
        write_check("max");
        run(4'd6, 2, "min");
        write_check("min uniform");

        reload();
        run(4'd7, 2, "avg");
        set_win(31, 31, 31, 31, 27);
        write_check("avg");

        reload();
        run(4'd8, 2, "rot ccw");
        set_win(28, 36, 27, 35, 27);
        write_check("rot ccw");
        run(4'd9, 2, "rot cw");
        set_win(27, 28, 35, 36, 27);
        write_check("rot cw");
        run(4'd10, 2, "mirror x");
        set_win(35, 36, 27, 28, 27);
        write_check("mirror x");
        run(4'd11, 2, "mirror y");
        set_win(36, 35, 28, 27, 27);
        write_check("mirror y");

        reload();
        for (int k = 0; k < 5; k++) run(4'd3, 1, "left");
        run(4'd5, 2, "max left");
        set_win(33, 33, 33, 33, 24);
        write_check("left sat");

        run(4'd13, 1, "center");
        for (int k = 0; k < 5; k++) run(4'd2, 1, "down");
        for (int k = 0; k < 5; k++) run(4'd4, 1, "right");
        run(4'd6, 2, "min corner");
        set_win(54, 54, 54, 54, 54);
        write_check("down right sat");

        for (int k = 0; k < 7; k++) run(4'd1, 1, "up");
        run(4'd5, 2, "max top");
        set_win(15, 15, 15, 15, 6);
        write_check("up sat");

        run(4'd14, 1, "nop14");
        run(4'd15, 1, "nop15");
        write_check("nop");

        rom[27] = 8'd255; rom[28] = 8'd255; rom[35] = 8'd255; rom[36] = 8'd255;
        reload();
        run(4'd7, 2, "avg kept point");
        set_win(10, 10, 10, 10, 6);
        write_check("avg after reload");
        run(4'd13, 1, "center");
        run(4'd7, 2, "avg 255");
        set_win(255, 255, 255, 255, 27);
        write_check("avg 255");

        cmd = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        cmd = 4'd12;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        cmd = 4'd0;
        wait_idle(n);
        chk("busy with ignored cmd", n, 52);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[i] !== exp_img[i]) bad++;
        chk("ignored cmd image mismatches", bad, 0);
        run(4'd14, 1, "nop after ignore");

        rom[27] = 8'd27; rom[28] = 8'd28; rom[35] = 8'd35; rom[36] = 8'd36;
        begin
            int w0;
            w0 = wr_cnt;
            cmd = 4'd0;
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            n = 0;
            while (IRAM_A !== 6'd20 && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("reach IRAM_A 20", IRAM_A, 20);
            reset = 1'b1;
            @(negedge clk);
            chk("abort IRAM_valid", IRAM_valid, 0);
            chk("abort busy", busy, 1);
            chk("abort IROM_A", IROM_A, 0);
            chk("abort IROM_rd", IROM_rd, 1);
            chk("abort writes", wr_cnt - w0, 21);
            reset = 1'b0;
            wait_idle(n);
            chk("load after abort cycles", n, 65);
        end
        for (int i = 0; i < 64; i++) exp_img[i] = rom[i];
        run(4'd8, 2, "rot after reset");
        set_win(28, 36, 27, 35, 27);
        write_check("after reset");
        chk("done with valid overlap", overlap, 0);

        @(negedge clk);
        chk("sb4 reset busy", busy4, 1);
        reset4 = 1'b0;
        n = 0;
        while (busy4 === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("sb4 load cycles", n, 257);
        cmd4 = 4'd0;
        cmd_valid4 = 1'b1;
        @(negedge clk);
        cmd_valid4 = 1'b0;
        n = 0;
        while (busy4 === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("sb4 write busy cycles", n, 257);
        chk("sb4 write count", wr4, 256);
        chk("sb4 done pulses", done4_cnt, 1);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram4[i] !== 8'(i)) bad++;
        chk("sb4 image mismatches", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
